// File: rtl/mips_pkg.sv
// Shared loader types and defaults for the instruction-memory boot path.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package mips_pkg;

  localparam int MEM_DEPTH_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream; pulses word_done_o
// in the cycle the fourth byte is presented, with the full word on word_o.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear_i) begin
      idx_d = 2'd0;
      buf_d = 24'd0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      buf_d = {buf_q[15:0], byte_data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // The first three bytes sit in buf_q; the fourth is taken straight from the input.
  assign word_o      = {buf_q, byte_data_i};
  assign word_done_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory and
// holds the CPU in reset until it is complete. Optional macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [AW:0] ONE     = 1;

  load_state_e   state_q, state_d;
  logic [7:0]    lenHi_q, lenHi_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   wordsLoaded_q, wordsLoaded_d;
  logic          memWe_q, memWe_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [31:0]   memWdata_q, memWdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          fire;
  logic          packClear;
  logic          wordDone;
  logic [31:0]   packedWord;
  logic [15:0]   lenWord;
  logic [AW:0]   wordsNext;

  assign in_ready  = (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign fire      = in_valid && in_ready;
  assign lenWord   = {lenHi_q, in_data};
  assign wordsNext = wordsLoaded_q + ONE;

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (packClear),
    .byte_valid_i (fire && (state_q == ST_DATA)),
    .byte_data_i  (in_data),
    .word_done_o  (wordDone),
    .word_o       (packedWord)
  );

  always_comb begin
    state_d       = state_q;
    lenHi_d       = lenHi_q;
    count_d       = count_q;
    wordsLoaded_d = wordsLoaded_q;
    memWe_d       = 1'b0;
    memAddr_d     = memAddr_q;
    memWdata_d    = memWdata_q;
    packClear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d         = chk_q;
`endif
    case (state_q)
      ST_LEN_HI: begin
        if (fire) begin
          lenHi_d = in_data;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (fire) begin
          if (lenWord == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end else if ({16'd0, lenWord} > DEPTH_W) begin
            state_d = ST_ERROR;
          end else begin
            count_d = lenWord[AW:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (fire) chk_d = chk_q ^ in_data;
`endif
        // Register the write so it lands the cycle after the word's last byte.
        if (wordDone) begin
          memWe_d       = 1'b1;
          memAddr_d     = wordsLoaded_q[AW-1:0];
          memWdata_d    = packedWord;
          wordsLoaded_d = wordsNext;
          if (wordsNext == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (fire) state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d       = ST_LEN_HI;
          wordsLoaded_d = '0;
          packClear     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d         = 8'd0;
`endif
        end
      end
      default: state_d = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LEN_HI;
      lenHi_q       <= 8'd0;
      count_q       <= '0;
      wordsLoaded_q <= '0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      lenHi_q       <= lenHi_d;
      count_q       <= count_d;
      wordsLoaded_q <= wordsLoaded_d;
      memWe_q       <= memWe_d;
      memAddr_q     <= memAddr_d;
      memWdata_q    <= memWdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q         <= chk_d;
`endif
    end
  end

  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign words_loaded = wordsLoaded_q;
  assign cpu_rst      = (state_q != ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: builds byte images, predicts the memory
// writes and final outcome from the stream format, and checks every cycle.
module tb_imem_loader;

  localparam int MEM_DEPTH = 1024;
  localparam int AW        = 10;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int          checks   = 0;
  int          failures = 0;
  wr_t         expQ[$];
  int          obsAddr[$];
  logic [31:0] obsData[$];
  logic [31:0] presetWords[$];

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Per-cycle rules plus the expected-write scoreboard.
  always @(negedge clk) begin : compareProc
    wr_t e;
    if (!rst) begin
      checkOutput("cpuRstRule", 32'(cpu_rst), 32'(!load_done));
      checkOutput("inReadyRule", 32'(in_ready), 32'(!(load_done || load_err)));
      if (mem_we) begin
        obsAddr.push_back(int'(mem_addr));
        obsData.push_back(mem_wdata);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWrite", 32'(mem_we), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("writeAddr", 32'(mem_addr), 32'(e.addr));
          checkOutput("writeData", mem_wdata, e.data);
          checkOutput("wordsAtWrite", 32'(words_loaded), 32'(e.addr + 1));
        end
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstMemWe", 32'(mem_we), 32'd0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
    checkOutput("rstMemWdata", mem_wdata, 32'd0);
    checkOutput("rstCpuRst", 32'(cpu_rst), 32'd1);
    checkOutput("rstLoadDone", 32'(load_done), 32'd0);
    checkOutput("rstLoadErr", 32'(load_err), 32'd0);
    checkOutput("rstWords", 32'(words_loaded), 32'd0);
  endtask

  task automatic sendBytes(input logic [7:0] bq[$], input int gapMode, output bit ok);
    bit toggle;
    bit sent;
    int guard;
    toggle = 1'b1;
    ok = 1'b1;
    foreach (bq[i]) begin
      sent = 1'b0;
      guard = 0;
      while (!sent && ok) begin
        @(negedge clk);
        case (gapMode)
          0: in_valid = 1'b1;
          1: begin
            in_valid = toggle;
            toggle = !toggle;
          end
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = in_valid ? bq[i] : 8'($urandom);
        sent = in_valid && in_ready;
        guard++;
        if (!sent && guard > 40) begin
          checkOutput("inReadyStall", 32'(in_ready), 32'd1);
          ok = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int gapMode, input bit badChk);
    logic [7:0]  bq[$];
    logic [15:0] n16;
    logic [31:0] w;
    bit          ok;
    bit          expOk;
    int          waitCnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = 8'd0;
`endif
    obsAddr.delete();
    obsData.delete();
    expQ.delete();
    n16 = 16'(n);
    bq.push_back(n16[15:8]);
    bq.push_back(n16[7:0]);
    if (n <= MEM_DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = (i < presetWords.size()) ? presetWords[i] : $urandom;
        expQ.push_back('{i, w});
        for (int b = 3; b >= 0; b--) begin
          bq.push_back(w[8*b +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
          x = x ^ w[8*b +: 8];
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      bq.push_back(badChk ? (x ^ 8'h01) : x);
`endif
    end
    expOk = (n <= MEM_DEPTH) && !badChk;
    sendBytes(bq, gapMode, ok);
    waitCnt = 0;
    while (!(load_done || load_err) && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("outcomeReached", 32'(load_done || load_err), 32'd1);
    @(negedge clk);
    checkOutput("loadDone", 32'(load_done), 32'(expOk));
    checkOutput("loadErr", 32'(load_err), 32'(!expOk));
    checkOutput("cpuRst", 32'(cpu_rst), 32'(!expOk));
    checkOutput("wordsLoaded", 32'(words_loaded), (n <= MEM_DEPTH) ? 32'(n) : 32'd0);
    checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reloadReady", 32'(in_ready), 32'd1);
    checkOutput("reloadCpuRst", 32'(cpu_rst), 32'd1);
    checkOutput("reloadWords", 32'(words_loaded), 32'd0);
    checkOutput("reloadDone", 32'(load_done), 32'd0);
    checkOutput("reloadErr", 32'(load_err), 32'd0);
  endtask

  // Hand-computed writes for the 00 02 12 34 56 78 9A BC DE F0 image.
  task automatic checkPinnedImage();
    checkOutput("pinnedCount", 32'(obsData.size()), 32'd2);
    if (obsData.size() >= 2) begin
      checkOutput("pinnedAddr0", 32'(obsAddr[0]), 32'd0);
      checkOutput("pinnedData0", obsData[0], 32'h12345678);
      checkOutput("pinnedAddr1", 32'(obsAddr[1]), 32'd1);
      checkOutput("pinnedData1", obsData[1], 32'h9ABCDEF0);
    end
  endtask

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    logic [7:0] partQ[$];
    bit         ok;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    #1 rst = 1'b1;
    #1 checkResetValues();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] two-word image, back-to-back");
    presetWords = '{32'h12345678, 32'h9ABCDEF0};
    applyStimulus(2, 0, 1'b0);
    checkPinnedImage();

    $display("[TB] two-word image, in_valid toggling");
    doReload();
    applyStimulus(2, 1, 1'b0);
    checkPinnedImage();

    $display("[TB] oversize and empty headers");
    presetWords.delete();
    doReload();
    applyStimulus(MEM_DEPTH + 1, 0, 1'b0);
    checkOutput("errNoWrites", 32'(obsData.size()), 32'd0);
    doReload();
    applyStimulus(0, 0, 1'b0);
    checkOutput("emptyNoWrites", 32'(obsData.size()), 32'd0);
    doReload();
    applyStimulus(65535, 2, 1'b0);

    $display("[TB] random images with random gaps");
    for (int k = 0; k < 6; k++) begin
      doReload();
      applyStimulus(int'($urandom_range(1, 12)), 2, 1'b0);
    end

    $display("[TB] full-depth image");
    doReload();
    applyStimulus(MEM_DEPTH, 0, 1'b0);
    checkOutput("fullCount", 32'(obsData.size()), 32'(MEM_DEPTH));
    if (obsAddr.size() > 0) checkOutput("fullLastAddr", 32'(obsAddr[$]), 32'd1023);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    presetWords = '{32'h01020304};
    doReload();
    applyStimulus(1, 0, 1'b0);
    doReload();
    applyStimulus(1, 0, 1'b1);
    presetWords.delete();
`endif
    doReload();

    $display("[TB] reset in the middle of a word");
    expQ.delete();
    partQ = '{8'h00, 8'h02, 8'h11, 8'h22};
    sendBytes(partQ, 0, ok);
    #2 rst = 1'b1;
    #1 checkResetValues();
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("weAfterRelease", 32'(mem_we), 32'd0);
    presetWords = '{32'h12345678, 32'h9ABCDEF0};
    applyStimulus(2, 0, 1'b0);
    checkPinnedImage();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, number of 32-bit instruction words the target memory holds.
REQ-002 Parameter AW, default 10, address width; SHALL equal clog2(MEM_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; transfer occurs when in_valid && in_ready.
REQ-008 reload  input  1  single-cycle request to restart loading from DONE or ERROR.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  AW  word address of the write.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_rst  output  1  holds the processor in reset while memory contents are invalid.
REQ-013 load_done  output  1  image loaded successfully.
REQ-014 load_err  output  1  image rejected.
REQ-015 words_loaded  output  AW+1  count of words written in the current load.

Function
REQ-016 States: LEN_HI, LEN_LO, DATA, CHK (only with CHECKSUM_EN), DONE, ERROR.
REQ-017 Stream format: 16-bit word count N, MSB first, then 4*N data bytes; each word big-endian (first byte -> bits 31:24).
REQ-018 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA, CHK and 0 in DONE and ERROR.
REQ-019 LEN_HI -> LEN_LO on transfer; LEN_LO -> DATA on transfer, capturing N.
REQ-020 N == 0 -> DONE directly from LEN_LO; N > MEM_DEPTH -> ERROR directly from LEN_LO.
REQ-021 In DATA, the 4th byte of a word accepted in cycle t SHALL produce mem_we=1 in cycle t+1 with mem_addr = word index (0,1,2,...) and the assembled mem_wdata.
REQ-022 Transfers may be back-to-back; in_valid gaps SHALL stall assembly without losing partial bytes.
REQ-023 words_loaded increments in the same cycle mem_we is asserted.
REQ-024 After the N-th word's byte is accepted: next state is CHK if CHECKSUM_EN, else DONE.
REQ-025 cpu_rst = 1 in every state except DONE; deasserts in the first cycle of DONE.
REQ-026 load_done = 1 only in DONE; load_err = 1 only in ERROR.
REQ-027 reload in DONE or ERROR -> LEN_HI next cycle, clearing words_loaded, byte index and checksum; cpu_rst reasserts in that cycle; reload ignored in other states.
REQ-028 mem_we SHALL never assert outside DATA-initiated writes; mem_addr never exceeds MEM_DEPTH-1.

Reset
REQ-029 rst SHALL force state LEN_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, load_done=0, load_err=0, words_loaded=0, immediately and regardless of clk.
REQ-030 rst mid-load SHALL discard partial words; no mem_we in the cycle after release.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN: when defined, one trailing byte follows the data; it SHALL equal the XOR of all 4*N data bytes; match -> DONE, mismatch -> ERROR; N == 0 expects checksum 0x00.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN: CHK state absent, no trailing byte consumed.

Structure
REQ-033 Shared package mips_pkg SHALL hold the loader state enum typedef and the MEM_DEPTH default constant.
REQ-034 One sub-module, byte_packer: shift-in of bytes, 2-bit index, word-complete pulse and 32-bit word output.

Verification
REQ-035 Stream 00 02 12 34 56 78 9A BC DE F0 -> writes addr0=0x12345678, addr1=0x9ABCDEF0; load_done=1, cpu_rst=0, words_loaded=2.
REQ-036 Same stream with in_valid toggling every other cycle -> identical writes, only later.
REQ-037 Header 04 01 (N=1025) -> ERROR, load_err=1, no mem_we, cpu_rst=1.
REQ-038 Header 00 00 -> DONE with no writes; with CHECKSUM_EN, trailing 00 required.
REQ-039 CHECKSUM_EN: N=1 word 0x01020304 then 0x04 -> DONE; then 0x05 -> ERROR; reload -> LEN_HI, cpu_rst=1.
REQ-040 rst asserted after 2 data bytes -> outputs at reset values immediately; fresh stream loads from addr0.
